// File: rtl/dpdmem_multi.sv
// dpdmem_multi: 1-write / 2-read TTA data memory with a post-reset clear sweep, range-checked sticky err.
// Define DPDMEM_MULTI_BYPASS_EN to forward same-cycle write data to a matching read port.
module dpdmem_multi #(
    parameter int                DATA_W  = 24,
    parameter int                ADDR_W  = 24,
    parameter int                DEPTH   = 128,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              ren1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              ready,
    output logic              err,
    input  logic              err_clr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One spare bit so DEPTH == 2**ADDR_W still compares correctly on the full address
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            r_state, w_next;
    logic [AW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic              r_rvalid0, r_rvalid1, r_err;
    logic              w_ready, w_win, w_rin0, w_rin1, w_byp0, w_byp1;
    logic              w_we, w_acc0, w_acc1, w_err_set;
    logic [AW-1:0]     w_wa;
    logic [DATA_W-1:0] w_wd, w_rd0, w_rd1;

    always_ff @(negedge clk) begin
        r_state <= rst ? S_CLEAR : w_next;
    end

    always_comb begin
        w_next = (r_state == S_CLEAR && r_ptr == AW'(DEPTH - 1)) ? S_READY : r_state;
    end

    always_comb begin
        w_ready   = r_state == S_READY;
        w_win     = {1'b0, waddr} < LIMIT;
        w_rin0    = {1'b0, raddr0} < LIMIT;
        w_rin1    = {1'b0, raddr1} < LIMIT;
`ifdef DPDMEM_MULTI_BYPASS_EN
        w_byp0    = wen && w_win && raddr0 == waddr;
        w_byp1    = wen && w_win && raddr1 == waddr;
`else
        w_byp0    = 1'b0;
        w_byp1    = 1'b0;
`endif
        w_we      = w_ready ? wen && w_win : 1'b1;
        w_wa      = w_ready ? waddr[AW-1:0] : r_ptr;
        w_wd      = w_ready ? wdata : CLR_VAL;
        w_acc0    = w_ready && ren0;
        w_acc1    = w_ready && ren1;
        w_rd0     = !w_rin0 ? '0 : w_byp0 ? wdata : r_mem[raddr0[AW-1:0]];
        w_rd1     = !w_rin1 ? '0 : w_byp1 ? wdata : r_mem[raddr1[AW-1:0]];
        w_err_set = w_ready && ((wen && !w_win) || (ren0 && !w_rin0) || (ren1 && !w_rin1));
    end

    always_ff @(negedge clk) begin
        if (!rst && w_we) r_mem[w_wa] <= w_wd;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (!w_ready) r_ptr <= r_ptr + AW'(1);
            r_rvalid0 <= w_acc0;
            r_rvalid1 <= w_acc1;
            if (w_acc0) r_rdata0 <= w_rd0;
            if (w_acc1) r_rdata1 <= w_rd1;
            r_err     <= w_err_set || (r_err && !err_clr);
        end
    end

    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign ready   = w_ready;
    assign err     = r_err;
endmodule

// File: tb/tb_dpdmem_multi.sv
// tb_dpdmem_multi: directed bench with a memory model and per-port expected-read queues.
module tb_dpdmem_multi;
    localparam logic [23:0] CLR = 24'h5A5A5A;

    logic        clk = 1'b0;
    logic        rst, wen, ren0, ren1, err_clr;
    logic [23:0] waddr, wdata, raddr0, raddr1, rdata0, rdata1;
    logic        rvalid0, rvalid1, ready, err;

    logic [23:0] model [128];
    logic [23:0] q0 [$];
    logic [23:0] q1 [$];
    logic [23:0] last0, last1;
    logic        err_m;
    int          total = 0, fails = 0, n;

    always #5 clk = ~clk;

    dpdmem_multi #(.DATA_W(24), .ADDR_W(24), .DEPTH(128), .CLR_VAL(CLR)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0), .rvalid0(rvalid0),
        .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
        .ready(ready), .err(err), .err_clr(err_clr)
    );

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit inr(input logic [23:0] a);
        return a < 24'd128;
    endfunction

    function automatic logic [23:0] exp_rd(input logic [23:0] a, input bit we,
                                           input logic [23:0] wa, input logic [23:0] wd);
        if (!inr(a)) return 24'h0;
`ifdef DPDMEM_MULTI_BYPASS_EN
        if (we && inr(wa) && wa == a) return wd;
`endif
        return model[a[6:0]];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model[i] = CLR;
        err_m = 1'b0;
        last0 = 24'h0;
        last1 = 24'h0;
    endtask

    // One READY-state cycle: push expected reads, update the model, then compare after the edge
    task automatic step(input bit we, input logic [23:0] wa, input logic [23:0] wd,
                        input bit e0, input logic [23:0] a0, input bit e1, input logic [23:0] a1);
        logic [23:0] x0, x1;
        wen = we; waddr = wa; wdata = wd;
        ren0 = e0; raddr0 = a0; ren1 = e1; raddr1 = a1;
        if (e0) q0.push_back(exp_rd(a0, we, wa, wd));
        if (e1) q1.push_back(exp_rd(a1, we, wa, wd));
        err_m = (we && !inr(wa)) || (e0 && !inr(a0)) || (e1 && !inr(a1)) || (err_m && !err_clr);
        if (we && inr(wa)) model[wa[6:0]] = wd;
        cyc();
        x0 = e0 ? q0.pop_front() : last0;
        x1 = e1 ? q1.pop_front() : last1;
        last0 = x0;
        last1 = x1;
        chk("rvalid0", rvalid0, e0);
        chk("rdata0", rdata0, x0);
        chk("rvalid1", rvalid1, e1);
        chk("rdata1", rdata1, x1);
        chk("err", err, err_m);
        wen = 0; ren0 = 0; ren1 = 0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!ready && cnt < 300);
    endtask

    initial begin
        rst = 1; wen = 0; ren0 = 0; ren1 = 0; err_clr = 0;
        waddr = 0; wdata = 0; raddr0 = 0; raddr1 = 0;
        cyc();
        cyc();
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);

        // sweep with requests held that must all be ignored
        rst = 0; wen = 1; waddr = 3; wdata = 24'h111111;
        ren0 = 1; raddr0 = 3; ren1 = 1; raddr1 = 500;
        wait_ready(n);
        chk("clr_len", n, 128);
        chk("clr_rvalid0", rvalid0, 0);
        chk("clr_rdata0", rdata0, 0);
        chk("clr_err", err, 0);
        wen = 0; ren0 = 0; ren1 = 0;
        model_clear();

        step(0, 0, 0, 1, 0, 1, 3);
        step(0, 0, 0, 1, 127, 0, 0);

        step(1, 10, 24'hABCDEF, 0, 0, 0, 0);
        step(1, 11, 24'h123456, 0, 0, 0, 0);
        step(0, 0, 0, 1, 10, 1, 11);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 11, 1, 11);

        step(1, 128, 24'hFFFFFF, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 200);
        err_clr = 1;
        step(0, 0, 0, 1, 200, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        err_clr = 0;
        step(1, 24'h10000A, 24'h000000, 0, 0, 0, 0);
        step(0, 0, 0, 1, 10, 1, 24'hFFFFFF);
        err_clr = 1;
        step(0, 0, 0, 0, 0, 0, 0);
        err_clr = 0;
        step(1, 127, 24'h0000AA, 0, 0, 0, 0);
        step(0, 0, 0, 1, 127, 1, 126);

        step(1, 20, 24'h000001, 0, 0, 0, 0);
        step(1, 20, 24'h000002, 1, 20, 1, 20);
        step(0, 0, 0, 1, 20, 1, 20);

        // reset in the middle of the sweep
        rst = 1;
        cyc();
        rst = 0;
        repeat (60) cyc();
        chk("mid_ready", ready, 0);
        rst = 1;
        cyc();
        chk("mid_rst_ready", ready, 0);
        rst = 0;
        wait_ready(n);
        chk("mid_clr_len", n, 128);
        chk("mid_err", err, 0);
        model_clear();
        step(0, 0, 0, 1, 10, 1, 20);

        // reset during normal operation
        step(1, 5, 24'h777777, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 1, 300);
        rst = 1;
        cyc();
        chk("op_rst_rdata0", rdata0, 0);
        chk("op_rst_rdata1", rdata1, 0);
        chk("op_rst_rvalid0", rvalid0, 0);
        chk("op_rst_ready", ready, 0);
        chk("op_rst_err", err, 0);
        rst = 0;
        wait_ready(n);
        chk("op_clr_len", n, 128);
        model_clear();
        step(0, 0, 0, 1, 5, 0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
